// File: rtl/key_step_entry_if.sv
// Bus between the key/rotor front end and its neighbours.
// The master drives the keypad and rotor-load inputs. The slave returns the
// letter strobe and the rotor positions.
interface key_step_entry_if;
  logic        key_n;
  logic [4:0]  letter_idx;
  logic        load;
  logic [14:0] load_pos;
  logic [25:0] letter_out;
  logic        letter_valid;
  logic        idx_err;
  logic [4:0]  state1;
  logic [4:0]  state2;
  logic [4:0]  state3;

  modport master (
    output key_n, letter_idx, load, load_pos,
    input  letter_out, letter_valid, idx_err, state1, state2, state3
  );

  modport slave (
    input  key_n, letter_idx, load, load_pos,
    output letter_out, letter_valid, idx_err, state1, state2, state3
  );
endinterface

// File: rtl/key_step_entry.sv
// Enigma key entry front end.
// The raw push-button is synchronised and then debounced. Each accepted press
// steps the three rotors, including the middle-rotor double step, and
// presents a one-hot letter with a one-cycle valid strobe.
module key_step_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int NOTCH1          = 16,
  parameter int NOTCH2          = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  key_step_entry_if.slave  bus
);

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]       N1       = 5'(NOTCH1);
  localparam logic [4:0]       N2       = 5'(NOTCH2);

  // Rotor advance with an explicit 25 -> 0 wrap.
  function automatic logic [4:0] wrap_inc(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  // Out-of-range start positions collapse to A.
  function automatic logic [4:0] clip_pos(input logic [4:0] p);
    return (p > 5'd25) ? 5'd0 : p;
  endfunction

  logic             r_sync1, r_sync2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [25:0]      r_letter_out;
  logic             r_letter_valid;
  logic             r_idx_err;
  logic [4:0]       r_state1, r_state2, r_state3;

  logic             w_key_s;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             w_idx_ok;
  logic             w_step2, w_step3;

  assign w_key_s = r_sync2;

  // Two-flop synchroniser. Its reset value of 1 is the idle (released) level.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce next-state logic. A press is accepted on the last stable count cycle.
  always_comb begin
    // NOTE: defaults first, so that no path through the case statement infers a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      ST_RELEASED: begin
        if (!w_key_s) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (w_key_s) begin
          w_state_nxt = ST_RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
          w_accept    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (w_key_s) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!w_key_s) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_RELEASED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Debounce state and counter registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= ST_RELEASED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Stepping decisions are taken from the pre-step rotor positions.
  // The middle rotor double-steps when it sits on its own notch.
  assign w_idx_ok = (bus.letter_idx <= 5'd25);
  assign w_step2  = (r_state1 == N1) || (r_state2 == N2);
  assign w_step3  = (r_state2 == N2);

  // Letter and rotor registers. A load takes priority over an accept in the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_letter_out   <= '0;
      r_letter_valid <= 1'b0;
      r_idx_err      <= 1'b0;
      r_state1       <= 5'd0;
      r_state2       <= 5'd0;
      r_state3       <= 5'd0;
    end else begin
      r_letter_valid <= 1'b0;
      r_idx_err      <= 1'b0;
      if (bus.load) begin
        r_state1 <= clip_pos(bus.load_pos[4:0]);
        r_state2 <= clip_pos(bus.load_pos[9:5]);
        r_state3 <= clip_pos(bus.load_pos[14:10]);
      end else if (w_accept) begin
        if (w_idx_ok) begin
          r_letter_out   <= 26'd1 << bus.letter_idx;
          r_letter_valid <= 1'b1;
          r_state1       <= wrap_inc(r_state1);
          if (w_step2) r_state2 <= wrap_inc(r_state2);
          if (w_step3) r_state3 <= wrap_inc(r_state3);
        end else begin
          r_idx_err <= 1'b1;
        end
      end
    end
  end

  assign bus.letter_out   = r_letter_out;
  assign bus.letter_valid = r_letter_valid;
  assign bus.idx_err      = r_idx_err;
  assign bus.state1       = r_state1;
  assign bus.state2       = r_state2;
  assign bus.state3       = r_state3;

endmodule

// File: tb/tb_key_step_entry.sv
// Bench for key_step_entry with a short debounce window.
// It runs hand-built timing sequences, a vector table of load/press cases,
// and random operations checked against a rotor model.
module tb_key_step_entry;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;

  key_step_entry_if ifc();

  key_step_entry #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3),
    .NOTCH1(16),
    .NOTCH2(4)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  int cyc        = 0;
  int n_valid    = 0;
  int n_err      = 0;
  int n_both     = 0;
  int last_v_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (ifc.letter_valid) begin
      n_valid    <= n_valid + 1;
      last_v_cyc <= cyc;
    end
    if (ifc.idx_err) n_err <= n_err + 1;
    if (ifc.letter_valid && ifc.idx_err) n_both <= n_both + 1;
  end

  // Rotor and letter model.
  int          m1, m2, m3;
  logic [25:0] m_letter;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m1 = 0; m2 = 0; m3 = 0; m_letter = '0;
  endtask

  task automatic model_load(input logic [14:0] p);
    m1 = (int'(p[4:0])   > 25) ? 0 : int'(p[4:0]);
    m2 = (int'(p[9:5])   > 25) ? 0 : int'(p[9:5]);
    m3 = (int'(p[14:10]) > 25) ? 0 : int'(p[14:10]);
  endtask

  task automatic model_press(input int idx);
    int n1, n2, n3;
    if (idx > 25) return;
    n1 = (m1 + 1) % 26;
    n2 = ((m1 == 16) || (m2 == 4)) ? (m2 + 1) % 26 : m2;
    n3 = (m2 == 4) ? (m3 + 1) % 26 : m3;
    m1 = n1; m2 = n2; m3 = n3;
    m_letter = '0;
    m_letter[idx] = 1'b1;
  endtask

  task automatic do_load(input logic [14:0] p);
    ifc.load     = 1'b1;
    ifc.load_pos = p;
    tick();
    ifc.load = 1'b0;
    model_load(p);
  endtask

  // Clean press and release. Returns the cycle at which key_n fell.
  task automatic press(input int idx, output int start);
    ifc.letter_idx = 5'(idx);
    ifc.key_n      = 1'b0;
    start          = cyc;
    repeat (D + 8) tick();
    ifc.key_n = 1'b1;
    repeat (D + 8) tick();
    model_press(idx);
  endtask

  task automatic check_model(input string tag);
    check({tag, " state1"}, 32'(ifc.state1), 32'(m1));
    check({tag, " state2"}, 32'(ifc.state2), 32'(m2));
    check({tag, " state3"}, 32'(ifc.state3), 32'(m3));
    check({tag, " letter"}, 32'(ifc.letter_out), 32'(m_letter));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " letter"}, 32'(ifc.letter_out), 32'd0);
    check({tag, " valid"},  32'(ifc.letter_valid), 32'd0);
    check({tag, " err"},    32'(ifc.idx_err), 32'd0);
    check({tag, " state1"}, 32'(ifc.state1), 32'd0);
    check({tag, " state2"}, 32'(ifc.state2), 32'd0);
    check({tag, " state3"}, 32'(ifc.state3), 32'd0);
  endtask

  typedef struct {
    logic        do_load;
    logic [14:0] pos;
    logic        do_press;
    logic [4:0]  idx;
    logic [4:0]  e1, e2, e3;
    logic [25:0] e_letter;
    int          e_v, e_e;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int start, v0, e0, r0;

    // pos = {slow, middle, fast}; e1/e2/e3 = fast/middle/slow after the entry.
    tbl[0] = '{1'b1, {5'd0, 5'd3, 5'd16},   1'b1, 5'd2,  5'd17, 5'd4,  5'd0, 26'h0000004, 1, 0};
    tbl[1] = '{1'b0, 15'd0,                 1'b1, 5'd3,  5'd18, 5'd5,  5'd1, 26'h0000008, 1, 0};
    tbl[2] = '{1'b1, {5'd0, 5'd0, 5'd25},   1'b1, 5'd0,  5'd0,  5'd0,  5'd0, 26'h0000001, 1, 0};
    tbl[3] = '{1'b1, {5'd25, 5'd4, 5'd25},  1'b1, 5'd25, 5'd0,  5'd5,  5'd0, 26'h2000000, 1, 0};
    tbl[4] = '{1'b1, {5'd1, 5'd2, 5'd3},    1'b1, 5'd27, 5'd3,  5'd2,  5'd1, 26'h2000000, 0, 1};
    tbl[5] = '{1'b1, {5'd31, 5'd31, 5'd31}, 1'b0, 5'd0,  5'd0,  5'd0,  5'd0, 26'h2000000, 0, 0};
    tbl[6] = '{1'b1, {5'd0, 5'd4, 5'd16},   1'b1, 5'd10, 5'd17, 5'd5,  5'd1, 26'h0000400, 1, 0};
    tbl[7] = '{1'b1, {5'd5, 5'd12, 5'd20},  1'b1, 5'd31, 5'd20, 5'd12, 5'd5, 26'h0000400, 0, 1};
    tbl[8] = '{1'b1, {5'd26, 5'd30, 5'd7},  1'b0, 5'd0,  5'd7,  5'd0,  5'd0, 26'h0000400, 0, 0};

    reset          = 1'b1;
    ifc.key_n      = 1'b1;
    ifc.letter_idx = 5'd0;
    ifc.load       = 1'b0;
    ifc.load_pos   = 15'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    model_reset();
    check_zero("reset");

    // First clean press of A: one strobe, fixed latency, fast rotor steps.
    v0 = n_valid; e0 = n_err;
    press(0, start);
    check("press A valid count", 32'(n_valid - v0), 32'd1);
    check("press A err count", 32'(n_err - e0), 32'd0);
    check("press A latency", 32'(last_v_cyc - start), 32'(D + 3));
    check("press A letter", 32'(ifc.letter_out), 32'h0000001);
    check("press A state1", 32'(ifc.state1), 32'd1);
    check("press A state2", 32'(ifc.state2), 32'd0);
    check("press A state3", 32'(ifc.state3), 32'd0);

    // Two short bounces must not be accepted.
    v0 = n_valid; e0 = n_err;
    ifc.letter_idx = 5'd9;
    ifc.key_n = 1'b0; repeat (2) tick();
    ifc.key_n = 1'b1; repeat (2) tick();
    ifc.key_n = 1'b0; repeat (2) tick();
    ifc.key_n = 1'b1; repeat (D + 8) tick();
    check("glitch valid count", 32'(n_valid - v0), 32'd0);
    check("glitch err count", 32'(n_err - e0), 32'd0);
    check_model("glitch");

    // Stable press of Z. The release must not produce a second strobe.
    v0 = n_valid;
    press(25, start);
    check("press Z valid count", 32'(n_valid - v0), 32'd1);
    check("press Z letter", 32'(ifc.letter_out), 32'h2000000);
    check_model("press Z");

    // Vector table: optional load followed by an optional press.
    for (int i = 0; i < 9; i++) begin
      v0 = n_valid; e0 = n_err;
      if (tbl[i].do_load) do_load(tbl[i].pos);
      if (tbl[i].do_press) press(int'(tbl[i].idx), start);
      else repeat (2) tick();
      check($sformatf("vec%0d state1", i), 32'(ifc.state1), 32'(tbl[i].e1));
      check($sformatf("vec%0d state2", i), 32'(ifc.state2), 32'(tbl[i].e2));
      check($sformatf("vec%0d state3", i), 32'(ifc.state3), 32'(tbl[i].e3));
      check($sformatf("vec%0d letter", i), 32'(ifc.letter_out), 32'(tbl[i].e_letter));
      check($sformatf("vec%0d valid count", i), 32'(n_valid - v0), 32'(tbl[i].e_v));
      check($sformatf("vec%0d err count", i), 32'(n_err - e0), 32'(tbl[i].e_e));
    end

    // Load lands in the accept cycle: the load wins and the press is dropped.
    v0 = n_valid; e0 = n_err;
    ifc.letter_idx = 5'd7;
    ifc.key_n = 1'b0;
    repeat (D + 2) tick();
    do_load({5'd3, 5'd9, 5'd20});
    repeat (D + 4) tick();
    ifc.key_n = 1'b1;
    repeat (D + 8) tick();
    check("load+accept valid count", 32'(n_valid - v0), 32'd0);
    check("load+accept err count", 32'(n_err - e0), 32'd0);
    check("load+accept state1", 32'(ifc.state1), 32'd20);
    check("load+accept state2", 32'(ifc.state2), 32'd9);
    check("load+accept state3", 32'(ifc.state3), 32'd3);
    check_model("load+accept");

    // Reset while debouncing. A key still held afterwards is a fresh press.
    ifc.letter_idx = 5'd12;
    ifc.key_n = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_zero("mid-debounce reset");
    r0 = cyc; v0 = n_valid;
    repeat (D + 10) tick();
    check("post-reset valid count", 32'(n_valid - v0), 32'd1);
    check("post-reset latency", 32'(last_v_cyc - r0), 32'(D + 3));
    ifc.key_n = 1'b1;
    repeat (D + 8) tick();
    model_press(12);
    check("post-reset release count", 32'(n_valid - v0), 32'd1);
    check_model("post-reset");

    // Random loads, short glitches and presses against the model.
    for (int i = 0; i < 40; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      v0 = n_valid; e0 = n_err;
      if (op < 3) begin
        do_load(15'($urandom));
        repeat (2) tick();
        check($sformatf("rnd%0d load valid", i), 32'(n_valid - v0), 32'd0);
      end else if (op < 5) begin
        ifc.letter_idx = 5'($urandom);
        ifc.key_n = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        ifc.key_n = 1'b1;
        repeat (D + 4) tick();
        check($sformatf("rnd%0d glitch valid", i), 32'(n_valid - v0), 32'd0);
        check($sformatf("rnd%0d glitch err", i), 32'(n_err - e0), 32'd0);
      end else begin
        int idx;
        idx = int'($urandom_range(0, 31));
        press(idx, start);
        check($sformatf("rnd%0d press valid", i), 32'(n_valid - v0), (idx <= 25) ? 32'd1 : 32'd0);
        check($sformatf("rnd%0d press err", i), 32'(n_err - e0), (idx > 25) ? 32'd1 : 32'd0);
      end
      check_model($sformatf("rnd%0d", i));
    end

    check("valid and err together", 32'(n_both), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/key_step_entry.md
Name: key_step_entry

Overview:
- Front end of the cipher datapath; sits directly upstream of the plugboard stage.
- Turns a push-button plus a switch-selected letter index into a debounced, one-hot 26-bit letter with a one-cycle valid strobe.
- On each accepted keypress it advances the three rotor positions using Enigma stepping, including the middle-rotor double step, before the letter is presented.
- Rotor positions feed the rotor/reflector stage and the GUI.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles the synchronized key level must stay stable before it is accepted (10 ms at 50 MHz).
- CNT_W, 19, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- NOTCH1, 16, position of the fast rotor (state1) that steps the middle rotor when leaving it (Q).
- NOTCH2, 4, position of the middle rotor (state2) that steps itself and the slow rotor when leaving it (E).

Ports:
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- key_n  in  1  raw active-low push-button, asynchronous to CLOCK_50.
- letter_idx  in  5  letter index, 0=A..25=Z, sampled when a press is accepted.
- load  in  1  one-cycle request to load rotor start positions.
- load_pos  in  15  {slow[14:10], middle[9:5], fast[4:0]}; each field must be 0..25.
- letter_out  out  26  one-hot letter (bit n = letter n), held until the next accepted press.
- letter_valid  out  1  one-cycle strobe, coincident with a new letter_out.
- idx_err  out  1  one-cycle strobe when a press is accepted with letter_idx > 25.
- state1  out  5  fast rotor position, 0..25.
- state2  out  5  middle rotor position, 0..25.
- state3  out  5  slow rotor position, 0..25.

Behaviour:
- Reset values: letter_out=0, letter_valid=0, idx_err=0, state1..3=0, FSM=RELEASED, debounce counter=0, synchronizer flops=1.
- Reset has priority over every other input. Asserting reset mid-debounce discards the partial count.
- Synchronizer: key_n passes through two flops; the result is key_s.
- Debounce FSM states and transitions:
  - RELEASED: key_s=0 → PRESS_WAIT with counter cleared.
  - PRESS_WAIT: counter increments while key_s=0; key_s=1 → RELEASED with counter cleared; counter reaching DEBOUNCE_CYCLES-1 with key_s=0 → PRESSED and raise an internal accept pulse for that cycle.
  - PRESSED: key_s=1 → RELEASE_WAIT with counter cleared.
  - RELEASE_WAIT: mirrors PRESS_WAIT; bounce back to 0 → PRESSED; stable 1 for DEBOUNCE_CYCLES → RELEASED. No event is generated on release.
- A key held low through reset deassertion counts as a new press once DEBOUNCE_CYCLES have elapsed.
- Accept with letter_idx ≤ 25, registered on the edge after the accept cycle:
  - letter_out = 1 << letter_idx and letter_valid=1.
  - Rotors step on the same edge, so the new positions and the letter are visible together. Latency from key_s settling to letter_valid = DEBOUNCE_CYCLES+1 cycles.
- Stepping, computed from pre-step values:
  - state1 always increments.
  - state2 increments if state1==NOTCH1 or state2==NOTCH2 (double step).
  - state3 increments if state2==NOTCH2.
  - Every rotor wraps 25→0 using a compare, not modulo 32.
- Accept with letter_idx > 25: idx_err=1 for one cycle; letter_out and all rotor positions are unchanged; letter_valid=0.
- load=1: state1..3 take load_pos fields on the next edge. A field > 25 is loaded as 0.
- load and accept in the same cycle: load wins, the keypress is dropped, and no strobe is issued.
- letter_valid and idx_err are never high in the same cycle, and each is high for at most one cycle per press.
- Only accepted presses step the rotors; bounces never do.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset, then letter_idx=0 and a clean press held 10 cycles → exactly one letter_valid, letter_out=26'h0000001, state1..3=1,0,0, arriving 5 cycles after key_s falls.
- Glitch key_n low for 2 cycles, high, low 2 cycles → no letter_valid, positions unchanged. Then a stable press of letter_idx=25 → letter_out=26'h2000000, one strobe only, none on release.
- Load {0,3,16} (slow,middle,fast), then two presses → first press gives 0,4,17; second press (double step) gives 1,5,18.
- Load {0,0,25}, one press → state1 wraps to 0 and the others stay 0. Load {25,4,25}, one press → 0,5,0 (fast, middle and slow all wrap or step).
- letter_idx=27, one press → idx_err one cycle, letter_valid=0, letter_out and positions unchanged. Load 31 in every field → positions 0,0,0.
- Assert load and accept in the same cycle → loaded values win, no strobe. Assert reset during PRESS_WAIT → all outputs 0, and a held key produces one strobe after a fresh 4-cycle debounce.
